fetch_unit: RTL and testbench

//   Instruction-fetch stage. Owns the PC and issues requests to instruction memory.

---
 rtl/rv32_pkg.sv | 25 ++
 rtl/fetch_predecode.sv | 36 +++
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-side definitions: opcode constants, the fetch FSM state type and
// immediate sign-extension helpers used by the predecoder.
package rv32_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  // J-type immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecoder: picks the next fetch PC from the returned instruction word.
//   instr      in   32  instruction word from memory
//   pc         in   32  PC of instr
//   pred_taken in   1   predictor verdict for instr
//   next_pc    out  32  following fetch address, word aligned
//   is_ctrl    out  1   instr is JAL or a conditional branch
module fetch_predecode
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        pred_taken,
  output logic [31:0] next_pc,
  output logic        is_ctrl
);

  logic [6:0]  opc;
  logic [31:0] target;

  always_comb begin
    opc     = instr[6:0];
    is_ctrl = 1'b0;
    target  = pc + 32'd4;
    if (opc == OPC_JAL) begin
      is_ctrl = 1'b1;
      target  = pc + imm_j(instr);
    end else if (opc == OPC_BRANCH) begin
      is_ctrl = 1'b1;
      if (pred_taken) begin
        target = pc + imm_b(instr);
      end
    end
    next_pc = {target[31:2], 2'b00};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one outstanding request at a time to
// instruction memory, and hands {instr, pc, pred} to decode under a valid/stall handshake.
// EX redirects override the PC; a request already in flight is marked to be discarded.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   pred_taken                     predictor verdict for the word being returned
//   imem_req/imem_addr/imem_ready  request channel (addr word aligned)
//   imem_rvalid/imem_rdata         response channel
//   id_valid/id_instr/id_pc/id_pred_taken, id_stall   packet to decode
//   ex_redirect/ex_target          mispredict redirect from EX
//   stat_fetched/stat_redirects    statistics counters
//
// Configuration macro FETCH_STATS_EN: when defined, stat_fetched counts accepted packets
// and stat_redirects counts redirects (both wrap); when undefined both ports read 0.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_taken,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic              id_pred_taken,
  input  logic              id_stall,
  input  logic              ex_redirect,
  input  logic [31:0]       ex_target,
  output logic [STAT_W-1:0] stat_fetched,
  output logic [STAT_W-1:0] stat_redirects
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic         id_pred_q, id_pred_d;

  logic [31:0]  pd_next_pc;
  logic         pd_is_ctrl;
  logic         handoff;

  fetch_predecode u_predecode (
    .instr      (imem_rdata),
    .pc         (pc_q),
    .pred_taken (pred_taken),
    .next_pc    (pd_next_pc),
    .is_ctrl    (pd_is_ctrl)
  );

  assign handoff = id_valid_q & ~id_stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    id_valid_d = id_valid_q & ~handoff;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pred_d  = id_pred_q;

    if (ex_redirect) begin
      pc_d       = ex_target & 32'hFFFF_FFFC;
      id_valid_d = 1'b0;
      unique case (state_q)
        REQ: begin
          // Request goes out this edge anyway; its response must be dropped.
          if (imem_ready) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: begin
          if (imem_ready) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = REQ;
            kill_d  = 1'b0;
            if (!kill_q) begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rdata;
              id_pc_d    = pc_q;
              id_pred_d  = pred_taken;
              // Non-control words take the plain sequential path.
              pc_d       = pd_is_ctrl ? pd_next_pc : pc_q + 32'd4;
              if (id_stall) begin
                state_d = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!id_stall) begin
            state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'h0;
      id_pred_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pred_q  <= id_pred_d;
    end
  end

  // No request is presented while reset is held, even though the state is already REQ.
  assign imem_req      = (state_q == REQ) & rst_n;
  assign imem_addr     = pc_q;
  assign id_valid      = id_valid_q;
  assign id_instr      = id_instr_q;
  assign id_pc         = id_pc_q;
  assign id_pred_taken = id_pred_q;

`ifdef FETCH_STATS_EN
  logic [STAT_W-1:0] stat_fetched_q, stat_redirects_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fetched_q   <= '0;
      stat_redirects_q <= '0;
    end else begin
      if (handoff) begin
        stat_fetched_q <= stat_fetched_q + STAT_W'(1);
      end
      if (ex_redirect) begin
        stat_redirects_q <= stat_redirects_q + STAT_W'(1);
      end
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_redirects = stat_redirects_q;
`else
  assign stat_fetched   = '0;
  assign stat_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        imem_req, id_valid, id_pred_taken;
  logic [31:0] imem_addr, id_instr, id_pc, stat_fetched, stat_redirects;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .STAT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_taken     (pred_taken),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pred_taken  (id_pred_taken),
    .id_stall       (id_stall),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .stat_fetched   (stat_fetched),
    .stat_redirects (stat_redirects)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Next fetch address from ISA rules, immediates assembled with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                           input logic pred);
    int imm;
    imm = 4;
    if (w[6:0] == 7'h6F) begin
      imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
            - (w[31] ? (1 << 20) : 0);
    end else if (w[6:0] == 7'h63 && pred) begin
      imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
            - (w[31] ? 4096 : 0);
    end
    return (pc + 32'(imm)) & 32'hFFFF_FFFC;
  endfunction

  // Model state: a request is either outstanding, or a packet is being held, or fetch is
  // free to issue.
  logic [31:0] m_pc, m_instr, m_pcv, m_fetched, m_redirs;
  bit          m_out, m_hold, m_kill, m_valid, m_pred, m_issue, m_take;

  always @(posedge clk) begin
    m_issue = !m_out && !m_hold;
    m_take  = m_valid && !id_stall;
    if (!rst_n) begin
      m_pc = RESET_PC; m_out = 0; m_hold = 0; m_kill = 0; m_valid = 0;
      m_instr = NOP; m_pcv = 0; m_pred = 0; m_fetched = 0; m_redirs = 0;
    end else begin
      if (m_take) m_fetched++;
      if (ex_redirect) begin
        m_redirs++;
        m_valid = 0;
        if (m_issue) begin
          if (imem_ready) begin m_out = 1; m_kill = 1; end
        end else if (m_out) begin
          if (imem_rvalid) begin m_out = 0; m_kill = 0; end
          else m_kill = 1;
        end else m_hold = 0;
        m_pc = ex_target & 32'hFFFF_FFFC;
      end else begin
        if (m_take) m_valid = 0;
        if (m_issue) begin
          if (imem_ready) m_out = 1;
        end else if (m_out) begin
          if (imem_rvalid) begin
            m_out = 0;
            if (m_kill) m_kill = 0;
            else begin
              m_valid = 1; m_instr = imem_rdata; m_pcv = m_pc; m_pred = pred_taken;
              m_pc = ref_next(m_pc, imem_rdata, pred_taken);
              m_hold = id_stall;
            end
          end
        end else if (!id_stall) m_hold = 0;
      end
    end
  end

  task automatic compare();
    chk("imem_req", imem_req, !m_out && !m_hold && rst_n);
    if (!m_out && !m_hold) chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", id_valid, m_valid);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_pcv);
    chk("id_pred_taken", id_pred_taken, m_pred);
    chk("stat_fetched", stat_fetched, STATS ? m_fetched : 32'h0);
    chk("stat_redirects", stat_redirects, STATS ? m_redirs : 32'h0);
  endtask

  // ---------------- stimulus / memory ----------------
  bit          rnd = 0, log_on = 0, force_rst = 1, force_stall = 0, force_redirect = 0;
  logic [31:0] force_target = 32'h0;
  int          lat_fix = 0, n20 = 0;
  bit          pend = 0, req_seen = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 0, addr_seen = 0;
  logic [31:0] acc_log[$];
  logic [31:0] taken_log[$];

  function automatic logic [31:0] table_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0400_006F;  // jal x0, +0x40
      32'h50:  return 32'hFD1F_F06F;  // jal x0, -0x30
      32'h20:  return 32'hFE00_0CE3;  // beq x0, x0, -8
      default: return NOP;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(4))
      0:       return NOP;
      1:       return {r[31:7], 7'h6F};
      2:       return {r[31:7], 7'h63};
      3:       return {r[31:7], 7'h67};
      default: return r;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    compare();
    // Request accepted at the edge just past?
    if (req_seen && imem_ready && rst_n) begin
      pend = 1; pend_addr = addr_seen;
      pend_cnt = lat_fix >= 0 ? lat_fix : int'($urandom_range(2));
      if (log_on) acc_log.push_back(addr_seen);
    end
    if (!rst_n) pend = 0;
    imem_rvalid = 0;
    imem_rdata  = $urandom;
    pred_taken  = rnd ? 1'($urandom_range(1)) : 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1;
        imem_rdata  = rnd ? rand_word() : table_word(pend_addr);
        if (!rnd) begin
          pred_taken = (pend_addr == 32'h20 && n20 == 0);
          if (pend_addr == 32'h20) n20++;
        end
        pend = 0;
      end else pend_cnt--;
    end
    imem_ready  = rnd ? ($urandom_range(9) < 7) : 1'b1;
    id_stall    = rnd ? ($urandom_range(9) < 3) : force_stall;
    ex_redirect = rnd ? ($urandom_range(19) == 0) : force_redirect;
    ex_target   = rnd ? $urandom : force_target;
    rst_n       = rnd ? ($urandom_range(199) != 0) : !force_rst;
    if (log_on && id_valid && !id_stall) taken_log.push_back(id_pc);
    #1;
    req_seen  = imem_req;
    addr_seen = imem_addr;
  endtask

  task automatic wait_acc(input int n);
    int budget;
    budget = 60;
    while (acc_log.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (acc_log.size() < n) begin
      tests++; fails++;
      $display("FAIL wait_acc: got %0d requests, expected %0d", acc_log.size(), n);
    end
  endtask

  logic [31:0] exp_acc[15] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h50, 32'h20, 32'h18,
                               32'h1C, 32'h20, 32'h24, 32'h28, 32'h100, 32'h104, 32'h108};
  logic [31:0] exp_taken[13] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h50, 32'h20,
                                 32'h18, 32'h1C, 32'h20, 32'h24, 32'h100, 32'h104};

  initial begin
    // Pin the model's address arithmetic to hand-computed values.
    chk("ref jal +0x40", ref_next(32'h10, 32'h0400_006F, 1'b0), 32'h50);
    chk("ref beq taken", ref_next(32'h20, 32'hFE00_0CE3, 1'b1), 32'h18);
    chk("ref beq not taken", ref_next(32'h20, 32'hFE00_0CE3, 1'b0), 32'h24);
    chk("ref jal -0x30", ref_next(32'h50, 32'hFD1F_F06F, 1'b0), 32'h20);

    step(); step();
    chk("reset id_valid", id_valid, 32'h0);
    chk("reset id_instr", id_instr, NOP);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset imem_req", imem_req, 32'h0);

    force_rst = 0; log_on = 1;
    wait_acc(11);
    lat_fix = 3;
    wait_acc(12);                         // 0x28 in flight, slow response
    force_redirect = 1; force_target = 32'h103;
    step();
    force_redirect = 0; lat_fix = 0;
    wait_acc(13);                         // refetch at 0x100
    step();
    force_stall = 1;
    step();                               // response for 0x104 lands under stall
    repeat (3) begin
      step();
      chk("stall imem_req", imem_req, 32'h0);
      chk("stall id_pc", id_pc, 32'h104);
      chk("stall id_valid", id_valid, 32'h1);
    end
    force_stall = 0; lat_fix = 1;
    wait_acc(15);
    force_rst = 1; force_redirect = 1; force_target = 32'h200;
    step();                               // reset, redirect and rvalid together
    force_rst = 0; force_redirect = 0;
    step();
    chk("post-reset id_valid", id_valid, 32'h0);
    chk("post-reset imem_addr", imem_addr, RESET_PC);
    chk("post-reset imem_req", imem_req, 32'h1);
    chk("post-reset stat_fetched", stat_fetched, 32'h0);
    chk("post-reset stat_redirects", stat_redirects, 32'h0);
    log_on = 0;

    chk("request count", acc_log.size(), 15);
    for (int i = 0; i < 15; i++)
      chk($sformatf("request addr %0d", i), i < acc_log.size() ? acc_log[i] : 32'hX,
          exp_acc[i]);
    chk("delivered count", taken_log.size(), 13);
    for (int i = 0; i < 13; i++)
      chk($sformatf("delivered pc %0d", i), i < taken_log.size() ? taken_log[i] : 32'hX,
          exp_taken[i]);

    rnd = 1; lat_fix = -1;
    repeat (4000) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
